// File: rtl/fetch_flush_stage.sv
// -----------------------------------------------------------------------------
// fetch_flush_stage
//
// Fetch stage that owns the fetch PC, drives a synchronous-read instruction
// memory and registers the IF/ID pipeline stage. A taken branch (flush)
// redirects the PC to branch_target, discards every wrong-path instruction
// still in flight and counts the discards in a saturating counter. Decode
// back-pressure (stall) freezes fetch; the instruction that returns from
// memory during a stall is parked in a one-entry skid so nothing is lost.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   flush          in   squash wrong path, redirect to branch_target
//   branch_target  in   redirect address (used unmodified, incl. bits [1:0])
//   stall          in   hold IF/ID and fetch
//   imem_en        out  instruction memory read strobe (combinational)
//   imem_addr      out  instruction memory read address (= fetch PC)
//   imem_rdata     in   read data, valid one cycle after imem_en
//   if_id_valid    out  IF/ID holds a real instruction
//   if_id_pc       out  PC of the IF/ID instruction
//   if_id_instr    out  IF/ID instruction, NOP_INSTR when not valid
//   squash_count   out  saturating count of discarded instructions
// -----------------------------------------------------------------------------
module fetch_flush_stage #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [CNT_W-1:0]  squash_count
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    // Saturating add of a small increment to the discard counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    logic [ADDR_W-1:0] r_pc;
    logic              r_req_vld;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_hold_vld;
    logic [ADDR_W-1:0] r_hold_pc;
    logic [DATA_W-1:0] r_hold_instr;
    logic              r_if_id_valid;
    logic [ADDR_W-1:0] r_if_id_pc;
    logic [DATA_W-1:0] r_if_id_instr;
    logic [CNT_W-1:0]  r_squash_count;

    logic              w_issue;
    logic [1:0]        w_squash_inc;

    // A request may only go out when neither redirecting nor back-pressured.
    assign w_issue      = !flush && !stall;
    // Everything that a flush throws away: IF/ID, the in-flight read, the skid.
    assign w_squash_inc = {1'b0, r_if_id_valid} + {1'b0, r_req_vld} + {1'b0, r_hold_vld};

    assign imem_en      = w_issue;
    assign imem_addr    = r_pc;
    assign if_id_valid  = r_if_id_valid;
    assign if_id_pc     = r_if_id_pc;
    assign if_id_instr  = r_if_id_instr;
    assign squash_count = r_squash_count;

    // Fetch PC, request tracking, skid entry, IF/ID register and squash counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC;
            r_req_vld      <= 1'b0;
            r_req_pc       <= '0;
            r_hold_vld     <= 1'b0;
            r_hold_pc      <= '0;
            r_hold_instr   <= '0;
            r_if_id_valid  <= 1'b0;
            r_if_id_pc     <= '0;
            r_if_id_instr  <= NOP_INSTR;
            r_squash_count <= '0;
        end else if (flush) begin
            // Redirect wins over stall; the read returning this cycle is dropped.
            r_pc           <= branch_target;
            r_req_vld      <= 1'b0;
            r_hold_vld     <= 1'b0;
            r_if_id_valid  <= 1'b0;
            r_if_id_instr  <= NOP_INSTR;
            r_squash_count <= sat_add(r_squash_count, w_squash_inc);
        end else if (stall) begin
            // IF/ID and PC freeze; park the returning read so it is not lost.
            r_req_vld <= 1'b0;
            if (r_req_vld) begin
                r_hold_vld   <= 1'b1;
                r_hold_pc    <= r_req_pc;
                r_hold_instr <= imem_rdata;
            end else begin
                r_hold_vld   <= r_hold_vld;
            end
        end else begin
            r_pc      <= r_pc + PC_STEP;
            r_req_vld <= 1'b1;
            r_req_pc  <= r_pc;
            // The skid entry is older than any read returning now, so it goes first.
            if (r_hold_vld) begin
                r_hold_vld    <= 1'b0;
                r_if_id_valid <= 1'b1;
                r_if_id_pc    <= r_hold_pc;
                r_if_id_instr <= r_hold_instr;
            end else begin
                r_if_id_valid <= r_req_vld;
                r_if_id_pc    <= r_req_pc;
                r_if_id_instr <= r_req_vld ? imem_rdata : NOP_INSTR;
            end
        end
    end

endmodule
